// File: rtl/traffic_phase_scheduler.sv
// Four-approach intersection sequencer: latches sensor requests, grants green round-robin,
// and enforces min/max green, yellow, all-red clearance and an emergency all-red override.
module traffic_phase_scheduler #(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 8,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_tick,
    input  logic [3:0] i_req,
    input  logic       i_emergency,
    output logic [3:0] o_green,
    output logic [3:0] o_yellow,
    output logic [3:0] o_red,
    output logic [1:0] o_phase,
    output logic [1:0] o_state
);

    localparam int T1   = (MAX_GREEN > YELLOW_TIME) ? MAX_GREEN : YELLOW_TIME;
    localparam int TMAX = (T1 > ALLRED_TIME) ? T1 : ALLRED_TIME;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'b00,
        ST_GREEN  = 2'b01,
        ST_YELLOW = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    phase_q, phase_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    pend_q,  pend_d;
    logic [3:0]    phase_oh;
    logic [3:0]    set_mask;
    logic          others;
    logic          grant;

    // First pending approach after cur, wrapping back to cur itself last.
    function automatic logic [1:0] pick_next(input logic [1:0] cur, input logic [3:0] pend);
        logic [1:0] idx;
        logic       found;
        pick_next = cur;
        found     = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && pend[idx]) begin
                pick_next = idx;
                found     = 1'b1;
            end
        end
    endfunction

    assign phase_oh = 4'b0001 << phase_q;
    assign others   = |(pend_q & ~phase_oh);

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        timer_d = timer_q;
        grant   = 1'b0;
        case (state_q)
            ST_ALLRED: begin
                if (i_emergency) begin
                    timer_d = '0;
                end else if (i_tick) begin
                    if (timer_q == TW'(ALLRED_TIME - 1)) begin
                        state_d = ST_GREEN;
                        phase_d = pick_next(phase_q, pend_q);
                        timer_d = '0;
                        grant   = 1'b1;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_GREEN: begin
                // Emergency cuts green short immediately, independent of the tick strobe.
                if (i_emergency) begin
                    state_d = ST_YELLOW;
                    timer_d = '0;
                end else if (i_tick) begin
                    if (others && (timer_q >= TW'(MIN_GREEN - 1)) &&
                        (!i_req[phase_q] || (timer_q >= TW'(MAX_GREEN - 1)))) begin
                        state_d = ST_YELLOW;
                        timer_d = '0;
                    end else if (timer_q < TW'(MAX_GREEN - 1)) begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            ST_YELLOW: begin
                if (i_tick) begin
                    if (timer_q == TW'(YELLOW_TIME - 1)) begin
                        state_d = ST_ALLRED;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_ALLRED;
                timer_d = '0;
            end
        endcase
    end

    // The served approach's own sensor is ignored while it is green; grant clears win over sets.
    always_comb begin
        set_mask = i_req;
        if (state_q == ST_GREEN) begin
            set_mask[phase_q] = 1'b0;
        end
        pend_d = pend_q | set_mask;
        if (grant) begin
            pend_d[phase_d] = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_ALLRED;
            phase_q <= 2'd0;
            timer_q <= '0;
            pend_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
        end
    end

    assign o_green  = (state_q == ST_GREEN)  ? phase_oh : 4'b0000;
    assign o_yellow = (state_q == ST_YELLOW) ? phase_oh : 4'b0000;
    assign o_red    = ~(o_green | o_yellow);
    assign o_phase  = phase_q;
    assign o_state  = state_q;

endmodule
